// File: rtl/dma_io_responder.sv
// Peripheral end of the DMA I/O handshake: raises DREQ, serves IOR/IOW strobes
// from/into a local byte FIFO, and stops the block when EOP_N is seen.
module dma_io_responder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic             DREQ,
    input  logic             DACK,
    input  logic             IOR_N,
    input  logic             IOW_N,
    input  logic             EOP_N,
    inout  wire  [7:0]       DB,
    input  logic             enable,
    input  logic             dir,
    input  logic             push_valid,
    input  logic [7:0]       push_data,
    output logic             push_ready,
    output logic             pop_valid,
    output logic [7:0]       pop_data,
    input  logic             pop_ready,
    output logic             done,
    output logic [CNT_W-1:0] xfer_count,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, ARM, REQ, XFER, DONE} state_t;

    state_t         state, state_nx;
    logic           dir_q;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           ior_prev, iow_prev, eop_seen;

    logic           empty, full, active;
    logic           ior_rise, iow_rise, rd_edge, wr_edge, xfer_done;
    logic           bus_pop, bus_push, local_push, local_pop, do_push, do_pop;
    logic [7:0]     push_byte, db_out;
    logic           db_oe;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign active   = (state != IDLE);
    assign ior_rise = !ior_prev && IOR_N;
    assign iow_rise = !iow_prev && IOW_N;

    // Strobes count inside XFER; outside it only a DACK-qualified strobe can raise an error flag.
    assign rd_edge   = !dir_q && ior_rise && ((state == XFER) || (active && DACK));
    assign wr_edge   =  dir_q && iow_rise && ((state == XFER) || (active && DACK));
    assign xfer_done = (state == XFER) && (rd_edge || wr_edge);

    assign bus_pop    = xfer_done && rd_edge && !empty;
    assign bus_push   = xfer_done && wr_edge && !full;
    assign push_ready = !dir_q && !full && active;
    assign pop_valid  =  dir_q && !empty;
    assign local_push = push_valid && push_ready;
    assign local_pop  = pop_valid && pop_ready;
    assign do_push    = bus_push || local_push;
    assign do_pop     = bus_pop || local_pop;
    assign push_byte  = dir_q ? DB : push_data;

    assign pop_data = mem[rd_ptr];
    assign done     = (state == DONE);
    assign db_out   = empty ? 8'hFF : mem[rd_ptr];
    assign db_oe    = DACK && !IOR_N && !dir_q && (state == XFER);
    assign DB       = db_oe ? db_out : 8'hzz;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (enable) state_nx = ARM;
            ARM: begin
                if (!enable)
                    state_nx = IDLE;
                else if (dir_q ? !full : !empty)
                    state_nx = REQ;
            end
            REQ: begin
                if (DACK)
                    state_nx = XFER;
                else if (!enable)
                    state_nx = IDLE;
            end
            XFER: begin
                if (xfer_done || !DACK)
                    state_nx = (eop_seen || !EOP_N) ? DONE : ARM;
            end
            DONE: if (!enable) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            DREQ       <= 1'b0;
            dir_q      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            xfer_count <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            ior_prev   <= 1'b1;
            iow_prev   <= 1'b1;
            eop_seen   <= 1'b0;
        end else begin
            state    <= state_nx;
            DREQ     <= (state_nx == REQ);
            ior_prev <= IOR_N;
            iow_prev <= IOW_N;
            eop_seen <= (state == XFER) && (state_nx == XFER) && (eop_seen || !EOP_N);

            if (state == IDLE && state_nx == ARM) begin
                dir_q      <= dir;
                xfer_count <= '0;
                overflow   <= 1'b0;
                underflow  <= 1'b0;
            end else begin
                if (xfer_done)
                    xfer_count <= xfer_count + CNT_W'(1);
                if (rd_edge && empty)
                    underflow <= 1'b1;
                if (wr_edge && full)
                    overflow <= 1'b1;
            end

            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= push_byte;
    end

endmodule

// File: tb/tb_dma_io_responder.sv
// Directed bench for dma_io_responder with a 4-deep FIFO and a 3-bit counter
// so that FIFO-full and counter wrap are reachable in a short run.
module tb_dma_io_responder;

    logic       CLK, RESET, DACK, IOR_N, IOW_N, EOP_N;
    logic       enable, dir, push_valid, pop_ready;
    logic [7:0] push_data, pop_data, tb_db;
    logic       DREQ, push_ready, pop_valid, done, overflow, underflow;
    logic [2:0] xfer_count;
    logic       tb_db_en;
    tri0 [7:0]  DB;
    int         checks = 0;
    int         errors = 0;

    assign DB = tb_db_en ? tb_db : 8'hzz;

    dma_io_responder #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .DACK(DACK),
        .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N), .DB(DB),
        .enable(enable), .dir(dir),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
        .done(done), .xfer_count(xfer_count),
        .overflow(overflow), .underflow(underflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitDreq(input string tag);
        int n = 0;
        while (DREQ !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checkOutput(tag, 32'(DREQ), 1);
    endtask

    // One controller read cycle (peripheral->memory); optionally pulls EOP_N low.
    task automatic busRead(input logic [7:0] exp, input logic eop);
        waitDreq("dreq_before_read");
        DACK = 1'b1;
        step();
        checkOutput("dreq_drop_on_dack", 32'(DREQ), 0);
        IOR_N = 1'b0;
        EOP_N = !eop;
        #1;
        checkOutput("db_read_data", 32'(DB), 32'(exp));
        step();
        IOR_N = 1'b1;
        step();
        EOP_N = 1'b1;
        DACK  = 1'b0;
    endtask

    // One controller write cycle (memory->peripheral).
    task automatic busWrite(input logic [7:0] data);
        waitDreq("dreq_before_write");
        DACK = 1'b1;
        step();
        checkOutput("dreq_drop_on_dack_w", 32'(DREQ), 0);
        IOW_N    = 1'b0;
        tb_db    = data;
        tb_db_en = 1'b1;
        step();
        IOW_N = 1'b1;
        step();
        tb_db_en = 1'b0;
        DACK     = 1'b0;
    endtask

    // Raw DACK-qualified strobe regardless of DREQ, for the error paths.
    task automatic applyStimulus(input logic use_iow, input logic [7:0] data);
        DACK = 1'b1;
        if (use_iow) begin
            IOW_N    = 1'b0;
            tb_db    = data;
            tb_db_en = 1'b1;
        end else begin
            IOR_N = 1'b0;
        end
        step();
        IOW_N = 1'b1;
        IOR_N = 1'b1;
        step();
        tb_db_en = 1'b0;
        DACK     = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1;
        enable = 1'b0; dir = 1'b0; push_valid = 1'b0; push_data = 8'h00;
        pop_ready = 1'b0; tb_db = 8'h00; tb_db_en = 1'b0;
        step(2);
        checkOutput("rst_dreq", 32'(DREQ), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_count", 32'(xfer_count), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_underflow", 32'(underflow), 0);
        checkOutput("rst_push_ready", 32'(push_ready), 0);
        checkOutput("rst_pop_valid", 32'(pop_valid), 0);
        checkOutput("rst_db_hiz", 32'(DB), 0);
        RESET = 1'b0;

        // Peripheral->memory: three bytes out in order, then DREQ idles.
        $display("[TB] dir=0 three-byte block");
        enable = 1'b1; dir = 1'b0;
        step();
        checkOutput("arm_push_ready", 32'(push_ready), 1);
        checkOutput("arm_empty_no_dreq", 32'(DREQ), 0);
        push_valid = 1'b1;
        push_data = 8'h11; step();
        push_data = 8'h22; step();
        push_data = 8'h33; step();
        push_valid = 1'b0;
        busRead(8'h11, 1'b0);
        busRead(8'h22, 1'b0);
        busRead(8'h33, 1'b0);
        step(2);
        checkOutput("dreq_low_when_empty", 32'(DREQ), 0);
        checkOutput("count_after_three", 32'(xfer_count), 3);

        // Enable latency with data already buffered, then EOP on the 2nd transfer.
        $display("[TB] enable latency and EOP");
        enable = 1'b0; step();
        enable = 1'b1; step();
        push_valid = 1'b1;
        push_data = 8'h44; step();
        push_data = 8'h55; step();
        push_data = 8'h66; step();
        push_valid = 1'b0;
        enable = 1'b0; step();
        checkOutput("idle_dreq_low", 32'(DREQ), 0);
        enable = 1'b1; step();
        checkOutput("enable_latency_1", 32'(DREQ), 0);
        step();
        checkOutput("enable_latency_2", 32'(DREQ), 1);
        busRead(8'h44, 1'b0);
        busRead(8'h55, 1'b1);
        checkOutput("eop_done", 32'(done), 1);
        checkOutput("eop_dreq_low", 32'(DREQ), 0);
        checkOutput("eop_count", 32'(xfer_count), 2);
        step(2);
        checkOutput("done_holds_dreq_low", 32'(DREQ), 0);
        checkOutput("done_held", 32'(done), 1);
        enable = 1'b0; step();
        checkOutput("done_cleared_idle", 32'(done), 0);
        enable = 1'b1; step();
        checkOutput("rearm_count_clear", 32'(xfer_count), 0);
        busRead(8'h66, 1'b0);

        // Abort: DACK granted then withdrawn without a strobe.
        $display("[TB] DACK abort");
        push_valid = 1'b1; push_data = 8'h77; step();
        push_valid = 1'b0;
        waitDreq("dreq_before_abort");
        DACK = 1'b1; step();
        checkOutput("abort_xfer_dreq_low", 32'(DREQ), 0);
        DACK = 1'b0; step();
        checkOutput("abort_dreq_low", 32'(DREQ), 0);
        checkOutput("abort_count_kept", 32'(xfer_count), 1);
        step();
        checkOutput("abort_dreq_back", 32'(DREQ), 1);
        busRead(8'h77, 1'b0);
        checkOutput("count_after_abort", 32'(xfer_count), 2);

        applyStimulus(1'b0, 8'h00);
        checkOutput("underflow_set", 32'(underflow), 1);
        checkOutput("underflow_no_count", 32'(xfer_count), 2);
        checkOutput("underflow_no_overflow", 32'(overflow), 0);

        // Memory->peripheral: fill the FIFO, overflow, drain locally.
        $display("[TB] dir=1 fill and drain");
        enable = 1'b0; step();
        dir = 1'b1; enable = 1'b1; step();
        checkOutput("rearm_underflow_clear", 32'(underflow), 0);
        checkOutput("rearm_count_zero", 32'(xfer_count), 0);
        for (int i = 0; i < 4; i++) busWrite(8'hA0 + 8'(i));
        step(2);
        checkOutput("full_blocks_dreq", 32'(DREQ), 0);
        checkOutput("full_pop_valid", 32'(pop_valid), 1);
        checkOutput("full_head", 32'(pop_data), 32'h A0);
        checkOutput("count_four", 32'(xfer_count), 4);
        applyStimulus(1'b1, 8'hEE);
        checkOutput("overflow_set", 32'(overflow), 1);
        checkOutput("overflow_head_kept", 32'(pop_data), 32'h A0);
        pop_ready = 1'b1; step();
        pop_ready = 1'b0;
        waitDreq("dreq_after_local_pop");
        for (int i = 1; i < 4; i++) begin
            checkOutput("drain_data", 32'(pop_data), 32'(8'hA0 + 8'(i)));
            pop_ready = 1'b1; step();
            pop_ready = 1'b0;
        end
        checkOutput("drained_pop_valid", 32'(pop_valid), 0);

        for (int i = 0; i < 4; i++) busWrite(8'hB0 + 8'(i));
        checkOutput("count_wrap", 32'(xfer_count), 0);
        pop_ready = 1'b1;
        checkOutput("wrap_head0", 32'(pop_data), 32'h B0);
        step();
        checkOutput("wrap_head1", 32'(pop_data), 32'h B1);
        step();
        pop_ready = 1'b0;

        // Reset in the middle of a read transfer with two bytes buffered.
        $display("[TB] reset mid-transfer");
        enable = 1'b0; step();
        dir = 1'b0; enable = 1'b1; step();
        waitDreq("dreq_before_reset");
        DACK = 1'b1; step();
        IOR_N = 1'b0;
        #1;
        checkOutput("db_before_reset", 32'(DB), 32'h B2);
        RESET = 1'b1; enable = 1'b0;
        step();
        checkOutput("reset_dreq", 32'(DREQ), 0);
        checkOutput("reset_count", 32'(xfer_count), 0);
        checkOutput("reset_db_hiz", 32'(DB), 0);
        checkOutput("reset_push_ready", 32'(push_ready), 0);
        checkOutput("reset_pop_valid", 32'(pop_valid), 0);
        RESET = 1'b0; IOR_N = 1'b1; DACK = 1'b0; enable = 1'b1;
        step(3);
        checkOutput("reset_fifo_flushed", 32'(DREQ), 0);
        checkOutput("reset_push_ready_arm", 32'(push_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
